// File: rtl/gem_csc_match_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gem_csc_match_pkg                                                    |
// | Shared constants, entry layout and FSM encodings for the GEM-CSC     |
// | cluster matcher.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gem_csc_match_pkg;

    localparam int         MXCLST = 8;
    localparam logic [3:0] MXAGE  = 4'd7;

    localparam int HS_W    = 8;
    localparam int WG_W    = 6;
    localparam int REQWG_W = 7;
    localparam int PAD_W   = 8;
    localparam int ROLL_W  = 3;

    localparam logic [HS_W-1:0]    HS_MIN      = 8'd0;
    localparam logic [HS_W-1:0]    HS_ME1B_MAX = 8'd127;
    localparam logic [HS_W-1:0]    HS_ME1A_MIN = 8'd128;
    localparam logic [HS_W-1:0]    HS_MAX      = 8'd223;
    localparam logic [HS_W-1:0]    HS_INVALID  = 8'd224;
    localparam logic [REQWG_W-1:0] MAXWIRE     = 7'd47;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Geometry of one translated window; all that the match test looks at.
    typedef struct packed {
        logic            me1a;
        logic [WG_W-1:0] wire_lo;
        logic [WG_W-1:0] wire_hi;
        logic [HS_W-1:0] a_lo;
        logic [HS_W-1:0] a_hi;
        logic [HS_W-1:0] a_mi;
        logic [HS_W-1:0] b_lo;
        logic [HS_W-1:0] b_hi;
        logic [HS_W-1:0] b_mi;
    } clst_win_t;

    typedef struct packed {
        clst_win_t         win;
        logic [PAD_W-1:0]  pad;
        logic [ROLL_W-1:0] roll;
    } clst_entry_t;

endpackage
`default_nettype wire

// File: rtl/gem_clst_entry_compare.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gem_clst_entry_compare                                               |
// | Combinational match test of one buffered window against a request.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gem_clst_entry_compare
    import gem_csc_match_pkg::*;
(
    input  clst_win_t           win_i,
    input  logic                valid_i,
    input  logic [REQWG_W-1:0]  req_wire_i,
    input  logic [HS_W-1:0]     req_hs_i,
    output logic                hit_o,
    output logic [HS_W-1:0]     dhs_o
);

    logic            w_me1a_req;
    logic            w_me1b_req;
    logic            w_region_ok;
    logic            w_wire_ok;
    logic            w_bound_ok;
    logic [HS_W-1:0] w_lo;
    logic [HS_W-1:0] w_hi;
    logic [HS_W-1:0] w_mi;

    assign w_me1a_req = (req_hs_i >= HS_ME1A_MIN) && (req_hs_i <= HS_MAX);
    assign w_me1b_req = (req_hs_i <= HS_ME1B_MAX);

    assign w_lo = win_i.me1a ? win_i.a_lo : win_i.b_lo;
    assign w_hi = win_i.me1a ? win_i.a_hi : win_i.b_hi;
    assign w_mi = win_i.me1a ? win_i.a_mi : win_i.b_mi;

    assign w_region_ok = win_i.me1a ? w_me1a_req : w_me1b_req;

    assign w_wire_ok = (req_wire_i <= MAXWIRE)
                    && ({1'b0, win_i.wire_lo} <= req_wire_i)
                    && (req_wire_i <= {1'b0, win_i.wire_hi});

    // A bound of 224 marks a window outside this region and must never hit.
    assign w_bound_ok = (w_lo != HS_INVALID) && (w_hi != HS_INVALID)
                     && (w_lo <= req_hs_i) && (req_hs_i <= w_hi);

    assign hit_o = valid_i && w_region_ok && w_wire_ok && w_bound_ok;
    assign dhs_o = (req_hs_i >= w_mi) ? (req_hs_i - w_mi) : (w_mi - req_hs_i);

endmodule
`default_nettype wire

// File: rtl/gem_csc_cluster_matcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gem_csc_cluster_matcher                                              |
// | Aging buffer of GEM windows with a snapshot scan for best LCT match. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gem_csc_cluster_matcher #(
    parameter int         MXCLST = gem_csc_match_pkg::MXCLST,
    parameter logic [3:0] MXAGE  = gem_csc_match_pkg::MXAGE,
    parameter int         HSBITS = 8,
    parameter int         WGBITS = 6
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clst_vpf,
    input  logic                      clst_me1a,
    input  logic [WGBITS-1:0]         clst_wire_lo,
    input  logic [WGBITS-1:0]         clst_wire_hi,
    input  logic [HSBITS-1:0]         clst_me1ahs_lo,
    input  logic [HSBITS-1:0]         clst_me1ahs_hi,
    input  logic [HSBITS-1:0]         clst_me1ahs_mi,
    input  logic [HSBITS-1:0]         clst_me1bhs_lo,
    input  logic [HSBITS-1:0]         clst_me1bhs_hi,
    input  logic [HSBITS-1:0]         clst_me1bhs_mi,
    input  logic [7:0]                clst_pad,
    input  logic [2:0]                clst_roll,
    input  logic                      req_vpf,
    input  logic [6:0]                req_wire,
    input  logic [HSBITS-1:0]         req_hs,
    output logic                      busy,
    output logic                      match_done,
    output logic                      match_found,
    output logic [$clog2(MXCLST)-1:0] match_idx,
    output logic [7:0]                match_pad,
    output logic [2:0]                match_roll,
    output logic [HSBITS-1:0]         match_dhs,
    output logic [7:0]                drop_cnt,
    output logic [7:0]                ovwr_cnt
);

    import gem_csc_match_pkg::clst_entry_t;
    import gem_csc_match_pkg::ST_IDLE;
    import gem_csc_match_pkg::ST_SCAN;
    import gem_csc_match_pkg::ST_DONE;
    import gem_csc_match_pkg::HS_MIN;
    import gem_csc_match_pkg::HS_W;

    localparam int IDXW = $clog2(MXCLST);

    logic [1:0]        state_q;
    logic [IDXW-1:0]   wr_ptr_q;
    logic [IDXW-1:0]   scan_idx_q;
    clst_entry_t       buf_q [MXCLST];
    clst_entry_t       shd_q [MXCLST];
    logic [MXCLST-1:0] vld_q;
    logic [MXCLST-1:0] shd_vld_q;
    logic [3:0]        age_q [MXCLST];
    logic [7:0]        drop_cnt_q;
    logic [7:0]        ovwr_cnt_q;
    logic [6:0]        req_wire_q;
    logic [HS_W-1:0]   req_hs_q;

    logic              best_found_q;
    logic [IDXW-1:0]   best_idx_q;
    logic [7:0]        best_pad_q;
    logic [2:0]        best_roll_q;
    logic [HS_W-1:0]   best_dhs_q;

    logic              done_q;
    logic              found_q;
    logic [IDXW-1:0]   idx_q;
    logic [7:0]        pad_q;
    logic [2:0]        roll_q;
    logic [HS_W-1:0]   dhs_q;

    clst_entry_t       wr_entry_d;
    clst_entry_t       w_cur;
    logic              w_hit;
    logic [HS_W-1:0]   w_dhs;
    logic              w_accept;
    logic              w_better;

    always_comb begin
        wr_entry_d             = '0;
        wr_entry_d.win.me1a    = clst_me1a;
        wr_entry_d.win.wire_lo = clst_wire_lo;
        wr_entry_d.win.wire_hi = clst_wire_hi;
        wr_entry_d.win.a_lo    = clst_me1ahs_lo;
        wr_entry_d.win.a_hi    = clst_me1ahs_hi;
        wr_entry_d.win.a_mi    = clst_me1ahs_mi;
        wr_entry_d.win.b_lo    = clst_me1bhs_lo;
        wr_entry_d.win.b_hi    = clst_me1bhs_hi;
        wr_entry_d.win.b_mi    = clst_me1bhs_mi;
        wr_entry_d.pad         = clst_pad;
        wr_entry_d.roll        = clst_roll;
    end

    assign w_accept = (state_q == ST_IDLE) && req_vpf;

    // Valid/age bookkeeping; a same-clock write wins over expiry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            vld_q      <= '0;
            ovwr_cnt_q <= '0;
            for (int i = 0; i < MXCLST; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < MXCLST; i++) begin
                if (clst_vpf && (wr_ptr_q == IDXW'(i))) begin
                    vld_q[i] <= 1'b1;
                    age_q[i] <= '0;
                end else if (vld_q[i]) begin
                    if (age_q[i] == MXAGE) begin
                        vld_q[i] <= 1'b0;
                        age_q[i] <= '0;
                    end else begin
                        age_q[i] <= age_q[i] + 4'd1;
                    end
                end
            end
            if (clst_vpf) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (vld_q[wr_ptr_q] && (ovwr_cnt_q != 8'hFF))
                    ovwr_cnt_q <= ovwr_cnt_q + 8'd1;
            end
        end
    end

    // Payload storage needs no reset; validity lives in vld_q/shd_vld_q.
    always_ff @(posedge clock) begin
        if (clst_vpf) buf_q[wr_ptr_q] <= wr_entry_d;
        if (w_accept) shd_q <= buf_q;
    end

    assign w_cur = shd_q[scan_idx_q];

    gem_clst_entry_compare u_cmp (
        .win_i      (w_cur.win),
        .valid_i    (shd_vld_q[scan_idx_q]),
        .req_wire_i (req_wire_q),
        .req_hs_i   (req_hs_q),
        .hit_o      (w_hit),
        .dhs_o      (w_dhs)
    );

    // Strict less-than keeps the lowest index on equal distance.
    assign w_better = w_hit && (!best_found_q || (w_dhs < best_dhs_q));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            scan_idx_q   <= '0;
            req_wire_q   <= '0;
            req_hs_q     <= '0;
            shd_vld_q    <= '0;
            best_found_q <= 1'b0;
            best_idx_q   <= '0;
            best_pad_q   <= '0;
            best_roll_q  <= '0;
            best_dhs_q   <= HS_MIN;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            idx_q        <= '0;
            pad_q        <= '0;
            roll_q       <= '0;
            dhs_q        <= '0;
            drop_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_vpf) begin
                        req_wire_q   <= req_wire;
                        req_hs_q     <= req_hs;
                        shd_vld_q    <= vld_q;
                        scan_idx_q   <= '0;
                        best_found_q <= 1'b0;
                        best_idx_q   <= '0;
                        best_pad_q   <= '0;
                        best_roll_q  <= '0;
                        best_dhs_q   <= HS_MIN;
                        state_q      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_better) begin
                        best_found_q <= 1'b1;
                        best_idx_q   <= scan_idx_q;
                        best_pad_q   <= w_cur.pad;
                        best_roll_q  <= w_cur.roll;
                        best_dhs_q   <= w_dhs;
                    end
                    scan_idx_q <= scan_idx_q + 1'b1;
                    if (scan_idx_q == IDXW'(MXCLST - 1)) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    found_q <= best_found_q;
                    idx_q   <= best_idx_q;
                    pad_q   <= best_pad_q;
                    roll_q  <= best_roll_q;
                    dhs_q   <= best_dhs_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (req_vpf && (state_q != ST_IDLE) && (drop_cnt_q != 8'hFF))
                drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign match_done  = done_q;
    assign match_found = found_q;
    assign match_idx   = idx_q;
    assign match_pad   = pad_q;
    assign match_roll  = roll_q;
    assign match_dhs   = dhs_q;
    assign drop_cnt    = drop_cnt_q;
    assign ovwr_cnt    = ovwr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gem_csc_cluster_matcher.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gem_csc_cluster_matcher                                           |
// | Directed self-checking bench for gem_csc_cluster_matcher.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gem_csc_cluster_matcher;

    logic       clock;
    logic       reset_n;
    logic       clst_vpf;
    logic       clst_me1a;
    logic [5:0] clst_wire_lo;
    logic [5:0] clst_wire_hi;
    logic [7:0] clst_me1ahs_lo;
    logic [7:0] clst_me1ahs_hi;
    logic [7:0] clst_me1ahs_mi;
    logic [7:0] clst_me1bhs_lo;
    logic [7:0] clst_me1bhs_hi;
    logic [7:0] clst_me1bhs_mi;
    logic [7:0] clst_pad;
    logic [2:0] clst_roll;
    logic       req_vpf;
    logic [6:0] req_wire;
    logic [7:0] req_hs;
    logic       busy;
    logic       match_done;
    logic       match_found;
    logic [2:0] match_idx;
    logic [7:0] match_pad;
    logic [2:0] match_roll;
    logic [7:0] match_dhs;
    logic [7:0] drop_cnt;
    logic [7:0] ovwr_cnt;

    int total = 0;
    int bad   = 0;
    int lat;
    int dones;

    gem_csc_cluster_matcher dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .clst_vpf       (clst_vpf),
        .clst_me1a      (clst_me1a),
        .clst_wire_lo   (clst_wire_lo),
        .clst_wire_hi   (clst_wire_hi),
        .clst_me1ahs_lo (clst_me1ahs_lo),
        .clst_me1ahs_hi (clst_me1ahs_hi),
        .clst_me1ahs_mi (clst_me1ahs_mi),
        .clst_me1bhs_lo (clst_me1bhs_lo),
        .clst_me1bhs_hi (clst_me1bhs_hi),
        .clst_me1bhs_mi (clst_me1bhs_mi),
        .clst_pad       (clst_pad),
        .clst_roll      (clst_roll),
        .req_vpf        (req_vpf),
        .req_wire       (req_wire),
        .req_hs         (req_hs),
        .busy           (busy),
        .match_done     (match_done),
        .match_found    (match_found),
        .match_idx      (match_idx),
        .match_pad      (match_pad),
        .match_roll     (match_roll),
        .match_dhs      (match_dhs),
        .drop_cnt       (drop_cnt),
        .ovwr_cnt       (ovwr_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic write_win(input bit me1a, input int wlo, input int whi,
                             input int alo, input int ahi, input int ami,
                             input int blo, input int bhi, input int bmi,
                             input int pad, input int roll);
        clst_me1a      = me1a;
        clst_wire_lo   = 6'(wlo);
        clst_wire_hi   = 6'(whi);
        clst_me1ahs_lo = 8'(alo);
        clst_me1ahs_hi = 8'(ahi);
        clst_me1ahs_mi = 8'(ami);
        clst_me1bhs_lo = 8'(blo);
        clst_me1bhs_hi = 8'(bhi);
        clst_me1bhs_mi = 8'(bmi);
        clst_pad       = 8'(pad);
        clst_roll      = 3'(roll);
        clst_vpf       = 1'b1;
        tick();
        clst_vpf       = 1'b0;
    endtask

    task automatic write_b(input int bmi, input int pad, input int roll);
        write_win(1'b0, 10, 14, 224, 224, 224, 40, 60, bmi, pad, roll);
    endtask

    task automatic write_a(input int pad, input int roll);
        write_win(1'b1, 10, 14, 130, 150, 140, 224, 224, 224, pad, roll);
    endtask

    task automatic request(input int w, input int hs);
        req_wire = 7'(w);
        req_hs   = 8'(hs);
        req_vpf  = 1'b1;
        tick();
        req_vpf  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((match_done !== 1'b1) && (n < 40));
    endtask

    task automatic check_result(input string tag, input int f, input int idx,
                                input int pad, input int roll, input int dhs);
        check({tag, "_found"}, int'(match_found), f);
        check({tag, "_idx"},   int'(match_idx),   idx);
        check({tag, "_pad"},   int'(match_pad),   pad);
        check({tag, "_roll"},  int'(match_roll),  roll);
        check({tag, "_dhs"},   int'(match_dhs),   dhs);
    endtask

    initial begin
        reset_n = 1'b0;
        clst_vpf = 1'b0; clst_me1a = 1'b0;
        clst_wire_lo = '0; clst_wire_hi = '0;
        clst_me1ahs_lo = '0; clst_me1ahs_hi = '0; clst_me1ahs_mi = '0;
        clst_me1bhs_lo = '0; clst_me1bhs_hi = '0; clst_me1bhs_mi = '0;
        clst_pad = '0; clst_roll = '0;
        req_vpf = 1'b0; req_wire = '0; req_hs = '0;
        #1;
        check("rst_done", int'(match_done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop_cnt), 0);
        check("rst_ovwr", int'(ovwr_cnt), 0);
        check_result("rst", 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;

        // Single hit: latency 9 from acceptance, dhs = |45-50|
        write_b(50, 37, 3);
        request(12, 45);
        check("single_busy", int'(busy), 1);
        wait_done(lat);
        check("single_lat", lat, 9);
        check_result("single", 1, 0, 37, 3, 5);
        tick();
        check("single_pulse", int'(match_done), 0);
        check("single_hold", int'(match_pad), 37);

        // Best of two, then tie goes to the lower index
        do_reset();
        write_b(50, 1, 1);
        write_b(47, 2, 2);
        request(12, 45);
        wait_done(lat);
        check_result("best", 1, 1, 2, 2, 2);
        do_reset();
        write_b(50, 1, 1);
        write_b(40, 2, 2);
        request(12, 45);
        wait_done(lat);
        check_result("tie", 1, 0, 1, 1, 5);

        // ME1a hit, then an ME1b request against an ME1a window zeroes outputs
        do_reset();
        write_a(5, 7);
        request(12, 135);
        wait_done(lat);
        check_result("me1a", 1, 0, 5, 7, 5);
        write_a(5, 7);
        request(12, 100);
        wait_done(lat);
        check_result("region", 0, 0, 0, 0, 0);

        // Lifetime edge: visible 8 clocks after write, gone at 9
        do_reset();
        write_b(50, 9, 4);
        repeat (7) tick();
        request(12, 45);
        wait_done(lat);
        check("age8_found", int'(match_found), 1);
        do_reset();
        write_b(50, 9, 4);
        repeat (8) tick();
        request(12, 45);
        wait_done(lat);
        check("age9_found", int'(match_found), 0);

        // Overflow: 10 writes wrap the pointer to 2
        do_reset();
        for (int k = 1; k <= 10; k++) write_win(1'b0, 0, 47, 224, 224, 224, 0, 127, 10 * k, k, 0);
        check("ovf_cnt", int'(ovwr_cnt), 2);
        request(12, 90);
        wait_done(lat);
        check_result("ovf_w9", 1, 0, 9, 0, 0);
        write_win(1'b0, 0, 47, 224, 224, 224, 0, 127, 77, 11, 1);
        request(12, 77);
        wait_done(lat);
        check_result("ovf_ptr", 1, 2, 11, 1, 0);
        check("ovf_cnt_hold", int'(ovwr_cnt), 2);
        do_reset();
        for (int k = 1; k <= 10; k++) write_win(1'b0, 0, 47, 224, 224, 224, 0, 127, 10 * k, k, 0);
        request(12, 100);
        wait_done(lat);
        check_result("ovf_w10", 1, 1, 10, 0, 0);

        // Busy drop and back-to-back acceptance after DONE
        do_reset();
        write_b(50, 37, 3);
        request(12, 45);
        dones = 0;
        for (int i = 1; i <= 9; i++) begin
            req_vpf = (i == 3);
            tick();
            req_vpf = 1'b0;
            if (match_done === 1'b1) dones++;
        end
        check("drop_dones", dones, 1);
        check("drop_done_now", int'(match_done), 1);
        check("drop_cnt", int'(drop_cnt), 1);
        check("drop_dhs", int'(match_dhs), 5);
        check("drop_idle", int'(busy), 0);
        request(12, 45);
        check("b2b_busy", int'(busy), 1);
        wait_done(lat);
        check("b2b_lat", lat, 9);
        check("b2b_found", int'(match_found), 0);
        check("b2b_drop", int'(drop_cnt), 1);

        // Reset in scan clock 4 clears outputs and the buffer, no stray DONE
        do_reset();
        write_b(50, 37, 3);
        request(12, 45);
        wait_done(lat);
        check("mid_pre_found", int'(match_found), 1);
        write_b(50, 37, 3);
        request(12, 45);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("mid_busy", int'(busy), 0);
        check_result("mid", 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        request(12, 45);
        wait_done(lat);
        check("mid_lat", lat, 9);
        check("mid_found", int'(match_found), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gem_csc_cluster_matcher.md
# gem_csc_cluster_matcher

Downstream of the GEM cluster-to-CSC window translator. Buffers the translated windows, one per clock: wire-group range, ME1a/ME1b key half-strip range, middle half-strip, pad and roll. Each buffered window lives for a fixed age window. On an LCT match request carrying a key wire group and key half-strip, the block scans a snapshot of the buffer one entry per clock and reports the best-matching GEM cluster to the GEM-CSC LCT builder.

## Interface
Parameters:
- MXCLST, 8, buffer depth in entries; must be a power of 2.
- MXAGE, 4'd7, clocks an entry stays valid after write.
- HSBITS, 8, half-strip field width (0-223 valid; 224 means invalid/not-in-region).
- WGBITS, 6, wire-group field width.

Ports:
- clock  in  1  main clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- clst_vpf  in  1  translated window valid this clock.
- clst_me1a  in  1  cluster maps to ME1a (roll 7).
- clst_wire_lo, clst_wire_hi  in  6  wire-group window bounds, inclusive.
- clst_me1ahs_lo, clst_me1ahs_hi, clst_me1ahs_mi  in  8  ME1a half-strip window and middle.
- clst_me1bhs_lo, clst_me1bhs_hi, clst_me1bhs_mi  in  8  ME1b half-strip window and middle.
- clst_pad  in  8  GEM pad 0-191.
- clst_roll  in  3  GEM roll 0-7.
- req_vpf  in  1  match request.
- req_wire  in  7  key wire group 0-47.
- req_hs  in  8  key half-strip 0-223; a value of 128 or more selects ME1a.
- busy  out  1  scan in progress; requests are not accepted.
- match_done  out  1  one-clock pulse, result valid.
- match_found  out  1  at least one entry matched.
- match_idx  out  3  buffer index of the winner.
- match_pad  out  8  winner pad.
- match_roll  out  3  winner roll.
- match_dhs  out  8  winner half-strip distance |req_hs − mi|.
- drop_cnt  out  8  requests dropped while busy; saturates at 255.
- ovwr_cnt  out  8  valid entries overwritten; saturates at 255.

## Operation
- **Write**
  - When clst_vpf=1, store the window in entry wr_ptr, set valid and age=0, and advance wr_ptr modulo MXCLST.
  - If the target entry was valid, increment ovwr_cnt.
  - Writes continue regardless of scan state.
- **Aging**
  - Each clock, every valid entry's age increments.
  - An entry whose age equals MXAGE is cleared the following clock.
  - A write to the same entry in the same clock takes priority over clearing.
- **FSM: IDLE → SCAN → DONE → IDLE**
  - IDLE: req_vpf=1 latches req_wire/req_hs, copies the full buffer (contents and valid) into a shadow, resets scan_idx=0, and goes to SCAN.
  - SCAN: evaluate shadow[scan_idx] and increment scan_idx. After index MXCLST−1, go to DONE.
  - DONE: assert match_done for one clock, drive the result, and return to IDLE.
  - A new request can be accepted in the IDLE clock that follows DONE.
- **Entry match condition**, all required:
  - entry valid;
  - wire_lo ≤ req_wire ≤ wire_hi;
  - if req_hs ≥ 128: entry me1a=1 and me1ahs_lo ≤ req_hs ≤ me1ahs_hi;
  - else: me1a=0 and me1bhs_lo ≤ req_hs ≤ me1bhs_hi.
  - Entries with bounds equal to 224 never match.
- **Best-match selection**
  - Distance is the unsigned 8-bit |req_hs − mi|, using the region's mi.
  - The smallest distance wins; on a tie, the lower index wins (strict less-than update).
- **Busy and drops:** busy=1 in SCAN and DONE. req_vpf=1 while busy is dropped and increments drop_cnt.
- **Held outputs:** when match_found=0, match_idx/pad/roll/dhs = 0. Result outputs hold their value until the next DONE.

## Timing
- **Reset:** all outputs 0, state IDLE, all entries invalid, wr_ptr=0, both counters 0.
- **Reset mid-scan:** the scan aborts and no match_done is issued.
- **Write visibility:** a window written at clock N is visible to a request accepted at clock N+1 or later. A request and a write in the same clock: the snapshot excludes that write.
- **Latency:** req accepted at clock N → match_done at N+MXCLST+1 (N+9 at default). Minimum request spacing is MXCLST+2 clocks.
- **Entry lifetime:** valid from clock N+1 through N+MXAGE+1 (N+8 at default).
- **Wrap-around:** wr_ptr wraps 7 → 0. With a window arriving every clock, each entry is overwritten before it expires, and ovwr_cnt increments.

## Structure
- **Shared package gem_csc_match_pkg:**
  - MXCLST, MXAGE;
  - HS constants 0/127/128/223 and the invalid value 224;
  - MAXWIRE=47;
  - entry field widths;
  - FSM state encodings IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
- **Sub-module gem_clst_entry_compare:** purely combinational. Takes one entry plus req_wire/req_hs; produces hit and dhs. It is instanced once on shadow[scan_idx].

## Test plan
- **Single cluster hit:** write wire 10-14, me1bhs 40-60, mi 50, pad 37, roll 3; request wire 12, hs 45 one clock later → match_done 9 clocks after the request, found=1, idx=0, pad=37, roll=3, dhs=5.
- **Best of two, then tie:**
  - Entries at idx0 (mi 50) and idx1 (mi 47), both covering hs 45 → idx=1, dhs=2.
  - Repeat with equal distances → idx=0.
- **Region mismatch and expiry:**
  - ME1a entry with me1ahs 130-150 and request hs 100 → found=0, outputs 0.
  - A valid ME1b entry requested 9 clocks after its write → found=0 (expired).
- **Overflow:** 10 consecutive writes → wr_ptr=2, ovwr_cnt=2; entries 0 and 1 hold writes 9 and 10.
- **Busy drop:** second req_vpf 3 clocks after an accepted request → ignored, drop_cnt=1, exactly one match_done. A request in the IDLE clock after DONE is accepted.
- **Reset mid-scan:** assert reset_n=0 at scan clock 4 → all outputs 0 immediately; no match_done after release; buffer empty.
